// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: the per-stage
// in-flight write record and forward-select sizing.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       is_load;
    logic [4:0] rd;
  } slot_t;

  function automatic int unsigned fsel_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic is_producer(slot_t s);
    return s.valid && s.reg_write && (s.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source operand against every tracked slot; the youngest
// producer wins and decides both the forward source and load-use hazard.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned FSEL_W     = 2
) (
  input  logic [4:0]              rs_i,
  input  logic                    used_i,
  input  slot_t [DEPTH-1:0]       slots_i,
  output logic [FSEL_W-1:0]       fwd_sel_o,
  output logic                    load_hit_o
);

  always_comb begin
    fwd_sel_o  = '0;
    load_hit_o = 1'b0;
    if (used_i && (rs_i != REG_ZERO)) begin
      // Walk oldest to youngest so the lowest-index match is the one left standing.
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (is_producer(slots_i[i]) && (slots_i[i].rd == rs_i)) begin
          fwd_sel_o  = FSEL_W'(i + 1);
          load_hit_o = slots_i[i].is_load && (i < int'(LOAD_READY));
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller: tracks in-flight writes from EX to WB,
// stalls on load-use, flushes the front end on an EX redirect, and counts both.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FSEL_W     = fsel_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic [FSEL_W-1:0] fwd_sel_rs1,
  output logic [FSEL_W-1:0] fwd_sel_rs2,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  slot_t [DEPTH-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_events_q, flush_events_d;

  logic hit_rs1, hit_rs2;
  logic stall, issue;

  hazard_match #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FSEL_W     (FSEL_W)
  ) u_match_rs1 (
    .rs_i       (id_rs1),
    .used_i     (id_rs1_used),
    .slots_i    (slots_q),
    .fwd_sel_o  (fwd_sel_rs1),
    .load_hit_o (hit_rs1)
  );

  hazard_match #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FSEL_W     (FSEL_W)
  ) u_match_rs2 (
    .rs_i       (id_rs2),
    .used_i     (id_rs2_used),
    .slots_i    (slots_q),
    .fwd_sel_o  (fwd_sel_rs2),
    .load_hit_o (hit_rs2)
  );

  // A redirect kills the ID instruction, so any hazard it had is moot.
  assign stall       = id_valid && (hit_rs1 || hit_rs2) && !ex_redirect;
  assign issue       = id_valid && !stall && !ex_redirect;
  assign stall_if_id = stall;
  assign bubble_ex   = stall || ex_redirect;
  assign flush_if_id = ex_redirect;

  always_comb begin
    slots_d = slots_q;
    for (int k = 1; k < int'(DEPTH); k++) begin
      slots_d[k] = slots_q[k-1];
    end
    if (issue) begin
      slots_d[0] = '{valid: 1'b1, reg_write: id_reg_write, is_load: id_is_load, rd: id_rd};
    end else begin
      slots_d[0] = '0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (ex_redirect && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q        <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      slots_q        <= slots_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DEPTH=3, LOAD_READY=2, CNT_W=4) with
// hand-computed expectations for forwarding, load-use stalls, redirects and saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DEPTH      = 3;
  localparam int unsigned LOAD_READY = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned FSEL_W     = 2;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used;
  logic              id_reg_write, id_is_load;
  logic              ex_redirect;
  logic              stall_if_id, bubble_ex, flush_if_id;
  logic [FSEL_W-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [CNT_W-1:0]  stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .CNT_W      (CNT_W),
    .FSEL_W     (FSEL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .flush_if_id  (flush_if_id),
    .fwd_sel_rs1  (fwd_sel_rs1),
    .fwd_sel_rs2  (fwd_sel_rs2),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one ID instruction (or idle); settles before returning.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic redir);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    ex_redirect  = redir;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset held: ID activity toggles but nothing may be tracked.
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check_eq("rst_stall", stall_if_id, 0);
    check_eq("rst_bubble", bubble_ex, 0);
    check_eq("rst_flush", flush_if_id, 0);
    check_eq("rst_fwd1", fwd_sel_rs1, 0);
    check_eq("rst_fwd2", fwd_sel_rs2, 0);
    check_eq("rst_stallcnt", stall_cycles, 0);
    check_eq("rst_flushcnt", flush_events, 0);
    idle(1);
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    check_eq("rel_fwd1", fwd_sel_rs1, 0);
    check_eq("rel_fwd2", fwd_sel_rs2, 0);
    idle(1);

    // ALU chain: add x5 ; sub x8,x5 ; x0-write reading x5,x8 ; reader of x0,x5
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    check_eq("alu_fwd1_slot0", fwd_sel_rs1, 1);
    check_eq("alu_fwd2_none", fwd_sel_rs2, 0);
    check_eq("alu_nostall", stall_if_id, 0);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    check_eq("alu_fwd1_slot1", fwd_sel_rs1, 2);
    check_eq("alu_fwd2_slot0", fwd_sel_rs2, 1);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    check_eq("alu_x0_fwd", fwd_sel_rs1, 0);
    check_eq("alu_fwd2_wb", fwd_sel_rs2, 3);
    step();
    // slot0 = no-write, slot1 = x0 write, slot2 = sub x8
    drive(1'b0, 5'd8, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check_eq("alu_fwd1_x8_wb", fwd_sel_rs1, 3);
    check_eq("alu_nowrite_fwd", fwd_sel_rs2, 0);
    idle(3);

    // Load-use, dependent directly after the load: 2 stall cycles.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    check_eq("lu_stall_c1", stall_if_id, 1);
    check_eq("lu_bubble_c1", bubble_ex, 1);
    check_eq("lu_flush_c1", flush_if_id, 0);
    check_eq("lu_fwd2_c1", fwd_sel_rs2, 1);
    step();
    check_eq("lu_stall_c2", stall_if_id, 1);
    check_eq("lu_bubble_c2", bubble_ex, 1);
    check_eq("lu_fwd2_c2", fwd_sel_rs2, 2);
    step();
    check_eq("lu_stall_c3", stall_if_id, 0);
    check_eq("lu_bubble_c3", bubble_ex, 0);
    check_eq("lu_fwd2_c3", fwd_sel_rs2, 3);
    check_eq("lu_stallcnt", stall_cycles, 2);
    step();
    idle(3);

    // Load-use with one independent instruction between: 1 stall cycle.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check_eq("lu1_indep_nostall", stall_if_id, 0);
    step();
    drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    check_eq("lu1_stall", stall_if_id, 1);
    check_eq("lu1_fwd1_slot1", fwd_sel_rs1, 2);
    step();
    check_eq("lu1_release", stall_if_id, 0);
    check_eq("lu1_fwd1_wb", fwd_sel_rs1, 3);
    check_eq("lu1_stallcnt", stall_cycles, 3);
    step();
    idle(3);

    // Youngest producer wins: x7 at slots 0 and 2.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_eq("yw_fwd1", fwd_sel_rs1, 1);
    check_eq("yw_fwd2", fwd_sel_rs2, 1);
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    check_eq("yw_unused_fwd2", fwd_sel_rs2, 0);
    idle(3);

    // Redirect arriving during a load-use stall.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    check_eq("rd_pre_stall", stall_if_id, 1);
    step();
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1);
    check_eq("rd_flush", flush_if_id, 1);
    check_eq("rd_stall", stall_if_id, 0);
    check_eq("rd_bubble", bubble_ex, 1);
    step();
    // Killed x13 writer must not appear in slot 0; the load is now in WB.
    drive(1'b1, 5'd13, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rd_killed_fwd", fwd_sel_rs1, 0);
    check_eq("rd_load_wb_fwd", fwd_sel_rs2, 3);
    check_eq("rd_flushcnt", flush_events, 1);
    check_eq("rd_stallcnt", stall_cycles, 4);
    check_eq("rd_flush_clear", flush_if_id, 0);
    idle(3);

    // Saturation: chained self-dependent loads stall 2 of every 3 cycles.
    drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step();
    check_eq("sat_stallcnt", stall_cycles, 15);
    for (int i = 0; i < 6; i++) step();
    check_eq("sat_hold", stall_cycles, 15);

    // Asynchronous reset mid-stream, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_stallcnt", stall_cycles, 0);
    check_eq("arst_flushcnt", flush_events, 0);
    check_eq("arst_fwd1", fwd_sel_rs1, 0);
    check_eq("arst_stall", stall_if_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_mid_fwd1", fwd_sel_rs1, 0);
    check_eq("rel_mid_stall", stall_if_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
